// File: rtl/ethernet_pkg.sv
`default_nettype none
// ============================================================================
// ethernet_pkg : shared Ethernet framing constants, header type and helpers
// Rev 1.0
// ============================================================================
package ethernet_pkg;

  localparam int          ETH_HDR_BYTES     = 16;
  localparam logic [47:0] ETH_BCAST_MAC     = 48'hffff_ffff_ffff;
  localparam logic [47:0] ETH_MAC_ADDR_FPGA = 48'hfa16_3e55_ca02;
  localparam logic [47:0] ETH_MAC_ADDR_STIM = 48'h0cc4_7a88_c047;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [7:0]  dst;
    logic [7:0]  rsvd;
  } eth_hdr_t;

  typedef enum logic [1:0] {
    HDR0    = 2'd0,
    HDR1    = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } eth_rx_state_t;

  // Wire byte 0 is the MSB of a MAC address on the stream.
  function automatic logic [47:0] eth_bswap48(input logic [47:0] le);
    logic [47:0] be;
    be = '0;
    for (int i = 0; i < 6; i++) begin
      be[47-8*i -: 8] = le[8*i +: 8];
    end
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// axis_out_reg : single-entry ready/valid output register, no bubble on refill
// Rev 1.0
// ============================================================================
module axis_out_reg #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [KEEP_W-1:0] i_keep,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_can_load,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [KEEP_W-1:0] o_keep,
  output logic              o_last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;
  logic              r_last;

  assign o_can_load = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/eth_rx_deframe.sv
`default_nettype none
// ============================================================================
// eth_rx_deframe : parse 16-byte header, filter on dst MAC, forward payload.
// Option macro ETH_RX_BCAST_EN : also accept broadcast destination.
// Rev 1.0
// ============================================================================
module eth_rx_deframe
  import ethernet_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR_FPGA = ETH_MAC_ADDR_FPGA,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      stream_in_DATA,
  input  logic [7:0]       stream_in_KEEP,
  input  logic             stream_in_LAST,
  input  logic             stream_in_VALID,
  output logic             stream_in_READY,
  output logic [63:0]      stream_out_DATA,
  output logic [7:0]       stream_out_KEEP,
  output logic             stream_out_LAST,
  output logic             stream_out_VALID,
  input  logic             stream_out_READY,
  output logic [47:0]      hdr_src_mac,
  output logic [15:0]      hdr_ethertype,
  output logic [7:0]       hdr_dst,
  output logic             hdr_valid,
  output logic [CNT_W-1:0] cnt_rx_ok,
  output logic [CNT_W-1:0] cnt_drop
);

  localparam logic [1:0] ST_HDR0    = HDR0;
  localparam logic [1:0] ST_HDR1    = HDR1;
  localparam logic [1:0] ST_PAYLOAD = PAYLOAD;
  localparam logic [1:0] ST_DROP    = DROP;

  logic [1:0]       r_state;
  logic [15:0]      r_src_hi;
  logic [47:0]      r_hdr_src_mac;
  logic [15:0]      r_hdr_ethertype;
  logic [7:0]       r_hdr_dst;
  logic             r_hdr_valid;
  logic [CNT_W-1:0] r_cnt_ok;
  logic [CNT_W-1:0] r_cnt_drop;

  logic        w_in_beat;
  logic        w_out_can_load;
  logic        w_pay_load;
  logic        w_mac_hit;
  logic [47:0] w_dst_mac;

  assign w_dst_mac = eth_bswap48(stream_in_DATA[47:0]);

`ifdef ETH_RX_BCAST_EN
  assign w_mac_hit = (w_dst_mac == MAC_ADDR_FPGA) || (w_dst_mac == ETH_BCAST_MAC);
`else
  assign w_mac_hit = (w_dst_mac == MAC_ADDR_FPGA);
`endif

  assign stream_in_READY = (r_state == ST_PAYLOAD) ? w_out_can_load : 1'b1;
  assign w_in_beat       = stream_in_VALID && stream_in_READY;
  assign w_pay_load      = w_in_beat && (r_state == ST_PAYLOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_HDR0;
      r_src_hi        <= '0;
      r_hdr_src_mac   <= '0;
      r_hdr_ethertype <= '0;
      r_hdr_dst       <= '0;
      r_hdr_valid     <= 1'b0;
      r_cnt_ok        <= '0;
      r_cnt_drop      <= '0;
    end else begin
      r_hdr_valid <= 1'b0;
      if (w_in_beat) begin
        case (r_state)
          ST_HDR0: begin
            // Staged only; published hdr_* wait for the second header flit.
            r_src_hi <= {stream_in_DATA[55:48], stream_in_DATA[63:56]};
            if (stream_in_LAST) begin
              r_cnt_drop <= r_cnt_drop + CNT_W'(1);
            end else if (w_mac_hit) begin
              r_state <= ST_HDR1;
            end else begin
              r_state <= ST_DROP;
            end
          end
          ST_HDR1: begin
            r_hdr_src_mac   <= {r_src_hi,
                                stream_in_DATA[7:0],   stream_in_DATA[15:8],
                                stream_in_DATA[23:16], stream_in_DATA[31:24]};
            r_hdr_ethertype <= {stream_in_DATA[39:32], stream_in_DATA[47:40]};
            r_hdr_dst       <= stream_in_DATA[55:48];
            r_hdr_valid     <= 1'b1;
            if (stream_in_LAST) begin
              r_cnt_ok <= r_cnt_ok + CNT_W'(1);
              r_state  <= ST_HDR0;
            end else begin
              r_state  <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (stream_in_LAST) begin
              r_cnt_ok <= r_cnt_ok + CNT_W'(1);
              r_state  <= ST_HDR0;
            end
          end
          ST_DROP: begin
            if (stream_in_LAST) begin
              r_cnt_drop <= r_cnt_drop + CNT_W'(1);
              r_state    <= ST_HDR0;
            end
          end
          default: r_state <= ST_HDR0;
        endcase
      end
    end
  end

  axis_out_reg #(
    .DATA_W(64),
    .KEEP_W(8)
  ) u_out_reg (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_pay_load),
    .i_data     (stream_in_DATA),
    .i_keep     (stream_in_KEEP),
    .i_last     (stream_in_LAST),
    .i_ready    (stream_out_READY),
    .o_can_load (w_out_can_load),
    .o_valid    (stream_out_VALID),
    .o_data     (stream_out_DATA),
    .o_keep     (stream_out_KEEP),
    .o_last     (stream_out_LAST)
  );

  assign hdr_src_mac   = r_hdr_src_mac;
  assign hdr_ethertype = r_hdr_ethertype;
  assign hdr_dst       = r_hdr_dst;
  assign hdr_valid     = r_hdr_valid;
  assign cnt_rx_ok     = r_cnt_ok;
  assign cnt_drop      = r_cnt_drop;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_deframe.sv
`default_nettype none
// ============================================================================
// tb_eth_rx_deframe : directed + randomized frames against a frame-level model
// Rev 1.0
// ============================================================================
module tb_eth_rx_deframe;

  localparam logic [47:0] C_MAC   = 48'hfa163e55ca02;
  localparam logic [47:0] C_BCAST = 48'hffffffffffff;
`ifdef ETH_RX_BCAST_EN
  localparam bit C_BCAST_EN = 1'b1;
`else
  localparam bit C_BCAST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] stream_in_DATA;
  logic [7:0]  stream_in_KEEP;
  logic        stream_in_LAST;
  logic        stream_in_VALID;
  logic        stream_in_READY;
  logic [63:0] stream_out_DATA;
  logic [7:0]  stream_out_KEEP;
  logic        stream_out_LAST;
  logic        stream_out_VALID;
  logic        stream_out_READY = 1'b1;
  logic [47:0] hdr_src_mac;
  logic [15:0] hdr_ethertype;
  logic [7:0]  hdr_dst;
  logic        hdr_valid;
  logic [31:0] cnt_rx_ok;
  logic [31:0] cnt_drop;

  eth_rx_deframe dut (
    .clk              (clk),
    .reset            (reset),
    .stream_in_DATA   (stream_in_DATA),
    .stream_in_KEEP   (stream_in_KEEP),
    .stream_in_LAST   (stream_in_LAST),
    .stream_in_VALID  (stream_in_VALID),
    .stream_in_READY  (stream_in_READY),
    .stream_out_DATA  (stream_out_DATA),
    .stream_out_KEEP  (stream_out_KEEP),
    .stream_out_LAST  (stream_out_LAST),
    .stream_out_VALID (stream_out_VALID),
    .stream_out_READY (stream_out_READY),
    .hdr_src_mac      (hdr_src_mac),
    .hdr_ethertype    (hdr_ethertype),
    .hdr_dst          (hdr_dst),
    .hdr_valid        (hdr_valid),
    .cnt_rx_ok        (cnt_rx_ok),
    .cnt_drop         (cnt_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_ok = 0;
  int exp_drop = 0;
  int timeouts = 0;
  int rdy_low = 0;
  int stall_err = 0;
  int out_mode = 0;

  typedef logic [72:0] flit_t;
  flit_t       exp_q[$];
  flit_t       got_q[$];
  logic [71:0] exp_h[$];
  logic [71:0] got_h[$];
  logic [63:0] tx_d[$];
  logic [7:0]  tx_k[$];

  // 0: always ready, 1: toggle, 2: random
  always @(posedge clk) begin
    #1;
    case (out_mode)
      0:       stream_out_READY = 1'b1;
      1:       stream_out_READY = ~stream_out_READY;
      default: stream_out_READY = 1'($urandom_range(0, 1));
    endcase
  end

  bit    prev_stall = 1'b0;
  flit_t prev_f;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!stream_out_VALID ||
          {stream_out_DATA, stream_out_KEEP, stream_out_LAST} !== prev_f))
        stall_err++;
      prev_stall = stream_out_VALID && !stream_out_READY;
      prev_f     = {stream_out_DATA, stream_out_KEEP, stream_out_LAST};
      if (stream_out_VALID && stream_out_READY)
        got_q.push_back({stream_out_DATA, stream_out_KEEP, stream_out_LAST});
      if (hdr_valid)
        got_h.push_back({hdr_src_mac, hdr_ethertype, hdr_dst});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input bit gaps);
    bit done = 1'b0;
    int g = 0;
    stream_in_DATA  = d;
    stream_in_KEEP  = k;
    stream_in_LAST  = l;
    stream_in_VALID = 1'b1;
    while (!done && g < 200) begin
      @(negedge clk);
      done = stream_in_READY;
      if (!done) rdy_low++;
      @(posedge clk); #1;
      g++;
    end
    if (!done) timeouts++;
    stream_in_VALID = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic hdr_flits(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                           input logic [7:0] hd, output logic [63:0] f0, output logic [63:0] f1);
    logic [7:0] hb[16];
    for (int i = 0; i < 6; i++) hb[i]     = dst[47-8*i -: 8];
    for (int i = 0; i < 6; i++) hb[6 + i] = src[47-8*i -: 8];
    hb[12] = et[15:8];
    hb[13] = et[7:0];
    hb[14] = hd;
    hb[15] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      f0[8*i +: 8] = hb[i];
      f1[8*i +: 8] = hb[8 + i];
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      tx_d.push_back({$urandom, $urandom});
      case ($urandom_range(0, 7))
        0:       tx_k.push_back(8'h00);
        1:       tx_k.push_back(8'($urandom));
        default: tx_k.push_back(8'hff);
      endcase
    end
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                            input logic [7:0] hd, input bit runt, input bit gaps);
    logic [63:0] f0, f1;
    int n;
    bit hit;
    hdr_flits(dst, src, et, hd, f0, f1);
    n   = tx_d.size();
    hit = (dst == C_MAC) || (C_BCAST_EN && dst == C_BCAST);
    if (runt || !hit) begin
      exp_drop++;
    end else begin
      exp_ok++;
      exp_h.push_back({src, et, hd});
      for (int i = 0; i < n; i++) exp_q.push_back({tx_d[i], tx_k[i], 1'(i == n - 1)});
    end
    beat(f0, 8'hff, runt, gaps);
    if (!runt) begin
      beat(f1, 8'hff, 1'(n == 0), gaps);
      for (int i = 0; i < n; i++) beat(tx_d[i], tx_k[i], 1'(i == n - 1), gaps);
    end
    tx_d.delete();
    tx_k.delete();
  endtask

  task automatic check_all(input string tag);
    int g = 0;
    while (got_q.size() < exp_q.size() && g < 400) begin @(posedge clk); #1; g++; end
    if (g >= 400) timeouts++;
    repeat (4) begin @(posedge clk); #1; end
    chk({tag, " flit_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, " flit"}, got_q[i], exp_q[i]);
    chk({tag, " hdr_count"}, got_h.size(), exp_h.size());
    for (int i = 0; i < exp_h.size() && i < got_h.size(); i++)
      chk({tag, " hdr"}, got_h[i], exp_h[i]);
    chk({tag, " cnt_rx_ok"}, cnt_rx_ok, exp_ok);
    chk({tag, " cnt_drop"}, cnt_drop, exp_drop);
    chk({tag, " stall_stable"}, stall_err, 0);
    chk({tag, " timeouts"}, timeouts, 0);
    got_q.delete(); exp_q.delete(); got_h.delete(); exp_h.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, stream_out_VALID, 1'b0);
    chk({tag, " out_data"}, {stream_out_DATA, stream_out_KEEP, stream_out_LAST}, 73'd0);
    chk({tag, " hdr"}, {hdr_src_mac, hdr_ethertype, hdr_dst, hdr_valid}, 73'd0);
    chk({tag, " counters"}, {cnt_rx_ok, cnt_drop}, 64'd0);
  endtask

  initial begin
    logic [63:0] f0, f1;
    logic [63:0] p0, p1;
    int r;
    reset = 1'b1;
    stream_in_DATA = '0; stream_in_KEEP = '0; stream_in_LAST = 1'b0; stream_in_VALID = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset in_ready", stream_in_READY, 1'b1);

    // Directed unicast from the test plan
    tx_d = {64'h0100000100030000, 64'h5073930200000000};
    tx_k = {8'hff, 8'h0f};
    send_frame(C_MAC, 48'h0cc47a88c047, 16'h0800, 8'h00, 1'b0, 1'b0);
    check_all("unicast");
    chk("unicast hdr_src_mac", hdr_src_mac, 48'h0cc47a88c047);
    chk("unicast hdr_ethertype", hdr_ethertype, 16'h0800);

    // Destination mismatch
    rdy_low = 0;
    fill_random(3);
    send_frame(48'h112233445566, 48'h0cc47a88c047, 16'h0800, 8'h05, 1'b0, 1'b0);
    chk("mac_miss in_ready", rdy_low, 0);
    check_all("mac_miss");

    // Runt then a normal frame
    send_frame(C_MAC, 48'h0a0b0c0d0e0f, 16'h86dd, 8'h11, 1'b1, 1'b0);
    check_all("runt");
    fill_random(2);
    send_frame(C_MAC, 48'h001122334455, 16'h0806, 8'h22, 1'b0, 1'b0);
    check_all("after_runt");

    // Toggling downstream ready
    out_mode = 1;
    fill_random(4);
    send_frame(C_MAC, 48'h665544332211, 16'h1234, 8'h33, 1'b0, 1'b0);
    check_all("stall");
    out_mode = 0;

    // Broadcast
    fill_random(1);
    send_frame(C_BCAST, 48'h0cc47a88c047, 16'h0800, 8'h44, 1'b0, 1'b0);
    check_all("bcast");

    // Header-only frame
    send_frame(C_MAC, 48'hdeadbeef0001, 16'habcd, 8'h55, 1'b0, 1'b0);
    check_all("hdr_only");

    // Randomized back-to-back traffic
    out_mode = 2;
    for (int fr = 0; fr < 40; fr++) begin
      r = $urandom_range(0, 9);
      if (r != 7) fill_random($urandom_range(0, 5));
      send_frame((r <= 5 || r == 7) ? C_MAC : (r == 6) ? C_BCAST : {$urandom, 16'($urandom)},
                 {$urandom, 16'($urandom)}, 16'($urandom), 8'($urandom), 1'(r == 7), 1'b1);
    end
    check_all("random");
    out_mode = 0;
    @(posedge clk); #1;

    // Reset during the second payload flit
    p0 = {$urandom, $urandom};
    p1 = {$urandom, $urandom};
    hdr_flits(C_MAC, 48'h0cc47a88c047, 16'h0800, 8'h66, f0, f1);
    beat(f0, 8'hff, 1'b0, 1'b0);
    beat(f1, 8'hff, 1'b0, 1'b0);
    beat(p0, 8'hff, 1'b0, 1'b0);
    stream_in_DATA = p1; stream_in_KEEP = 8'hff; stream_in_LAST = 1'b0; stream_in_VALID = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("midreset");
    reset = 1'b0;
    stream_in_VALID = 1'b0;
    got_q.delete(); exp_q.delete(); got_h.delete(); exp_h.delete();
    exp_ok = 0; exp_drop = 0;
    repeat (2) begin @(posedge clk); #1; end
    fill_random(2);
    send_frame(C_MAC, 48'h0cc47a88c047, 16'h0800, 8'h77, 1'b0, 1'b0);
    check_all("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
